viterbi_acs_serial: RTL and testbench

// - Serial add-compare-select stage of the K-configurable rate-1/2 hard-decision Viterbi decoder.
// - Consumes one received 2-bit symbol per trellis step and evaluates one successor state per cycle.
// - Expected symbols come from an instance of expected_bits.
// - Emits one survivor-bit word per step, plus best state and best metric, to the traceback stage.

---
 rtl/viterbi_acs_serial_if.sv | 52 +++++
 rtl/viterbi_acs_serial.sv | 203 ++++++++++++++++++++
 tb/tb_viterbi_acs_serial.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_acs_serial_if.sv
// Bundle of the two handshakes around the serial ACS stage.
//   - Symbol side: sym_valid / sym_ready / sym (plus sym_erase when
//     VITERBI_ACS_ERASURE_EN is defined). Driven by the upstream demapper.
//   - Survivor side: surv_valid / surv_ready / surv_bits / best_state /
//     best_metric. Consumed by the traceback stage.
// Modports:
//   - master : upstream/downstream environment (drives sym, surv_ready)
//   - slave  : the ACS stage itself
// Optional feature macro: VITERBI_ACS_ERASURE_EN (adds sym_erase[1:0]).
interface viterbi_acs_serial_if #(
    parameter int K    = 5,
    parameter int PM_W = 8
);
    localparam int M  = K - 1;
    localparam int NS = 1 << M;

    logic            sym_valid;
    logic            sym_ready;
    logic [1:0]      sym;
`ifdef VITERBI_ACS_ERASURE_EN
    logic [1:0]      sym_erase;
`endif
    logic            surv_valid;
    logic            surv_ready;
    logic [NS-1:0]   surv_bits;
    logic [M-1:0]    best_state;
    logic [PM_W-1:0] best_metric;

`ifdef VITERBI_ACS_ERASURE_EN
    modport master (
        output sym_valid, input sym_ready, output sym, output sym_erase,
        input surv_valid, output surv_ready,
        input surv_bits, input best_state, input best_metric
    );
    modport slave (
        input sym_valid, output sym_ready, input sym, input sym_erase,
        output surv_valid, input surv_ready,
        output surv_bits, output best_state, output best_metric
    );
`else
    modport master (
        output sym_valid, input sym_ready, output sym,
        input surv_valid, output surv_ready,
        input surv_bits, input best_state, input best_metric
    );
    modport slave (
        input sym_valid, output sym_ready, input sym,
        output surv_valid, input surv_ready,
        output surv_bits, output best_state, output best_metric
    );
`endif
endinterface

// File: rtl/viterbi_acs_serial.sv
// Serial add-compare-select stage of a rate-1/2 hard-decision Viterbi decoder.
// One received symbol is accepted per trellis step; the successor states are
// evaluated one per cycle, then the metrics are normalised and a survivor
// word with the best state is presented to the traceback stage.
// Ports:
//   - clk   : rising-edge clock
//   - rst_n : asynchronous active-low reset
//   - clr   : synchronous re-init (metrics to reset values, FSM to IDLE)
//   - bus   : viterbi_acs_serial_if.slave (symbol in, survivor word out)
// Optional feature macro: VITERBI_ACS_ERASURE_EN (erased symbol bits add 0
// to the branch metric).

// Encoder output for the transition pred -> {pred, b}. Tap i of each
// generator selects bit i of the K-bit register {pred, b}.
module expected_bits #(
    parameter int K      = 5,
    parameter int G0_OCT = 'o23,
    parameter int G1_OCT = 'o35
) (
    input  logic [K-2:0] pred_i,
    input  logic         b_i,
    output logic [1:0]   exp_o
);
    localparam logic [K-1:0] G0 = K'(G0_OCT);
    localparam logic [K-1:0] G1 = K'(G1_OCT);

    logic [K-1:0] shiftReg;

    assign shiftReg = {pred_i, b_i};
    assign exp_o    = {^(shiftReg & G0), ^(shiftReg & G1)};
endmodule

module viterbi_acs_serial #(
    parameter int K       = 5,
    parameter int G0_OCT  = 'o23,
    parameter int G1_OCT  = 'o35,
    parameter int PM_W    = 8,
    parameter int INIT_PM = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    viterbi_acs_serial_if.slave  bus
);
    localparam int M  = K - 1;
    localparam int NS = 1 << M;
    localparam logic [PM_W-1:0] INIT_VAL = PM_W'(INIT_PM);

    typedef enum logic [1:0] {IDLE, RUN, NORM, OUT} state_t;

    state_t          state_q;
    logic            symReady_q;
    logic            survValid_q;
    logic [NS-1:0]   survBits_q;
    logic [M-1:0]    bestState_q;
    logic [PM_W-1:0] bestMetric_q;
    logic [M-1:0]    cnt_q;
    logic [1:0]      symLatched_q;
    logic [1:0]      symErase_q;
    logic [PM_W-1:0] runMin_q;
    logic [M-1:0]    runMinIdx_q;
    logic [PM_W-1:0] pmOld_q [NS];
    logic [PM_W-1:0] pmNew_q [NS];

    logic [M-1:0]    pred0;
    logic [M-1:0]    pred1;
    logic            branchBit;
    logic [1:0]      exp0;
    logic [1:0]      exp1;
    logic [1:0]      diff0;
    logic [1:0]      diff1;
    logic [1:0]      bm0;
    logic [1:0]      bm1;
    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;
    logic            choose1_d;
    logic [PM_W-1:0] pmNew_d;

    // The state under evaluation is cnt_q; its two predecessors differ only in
    // the MSB, and its input bit is its own LSB.
    assign pred0     = {1'b0, cnt_q[M-1:1]};
    assign pred1     = {1'b1, cnt_q[M-1:1]};
    assign branchBit = cnt_q[0];

    expected_bits #(.K(K), .G0_OCT(G0_OCT), .G1_OCT(G1_OCT)) u_exp0 (
        .pred_i (pred0),
        .b_i    (branchBit),
        .exp_o  (exp0)
    );

    expected_bits #(.K(K), .G0_OCT(G0_OCT), .G1_OCT(G1_OCT)) u_exp1 (
        .pred_i (pred1),
        .b_i    (branchBit),
        .exp_o  (exp1)
    );

`ifdef VITERBI_ACS_ERASURE_EN
    logic [1:0] eraseMask;
    assign eraseMask = symErase_q;
`else
    logic [1:0] eraseMask;
    assign eraseMask = 2'b00;
`endif

    // Branch metrics, saturating candidate metrics and the select decision for
    // the current state. Ties keep the p0 branch.
    always_comb begin
        diff0     = (symLatched_q ^ exp0) & ~eraseMask;
        diff1     = (symLatched_q ^ exp1) & ~eraseMask;
        bm0       = {1'b0, diff0[1]} + {1'b0, diff0[0]};
        bm1       = {1'b0, diff1[1]} + {1'b0, diff1[0]};
        sum0      = {1'b0, pmOld_q[pred0]} + {{(PM_W-1){1'b0}}, bm0};
        sum1      = {1'b0, pmOld_q[pred1]} + {{(PM_W-1){1'b0}}, bm1};
        cand0     = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
        cand1     = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
        choose1_d = (cand1 < cand0);
        pmNew_d   = choose1_d ? cand1 : cand0;
    end

    // Control FSM plus the metric banks. pmOld_q stays untouched while RUN
    // walks the states, so every candidate in a step sees the old metrics;
    // the bank is refreshed (normalised by the running minimum) only in NORM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            symReady_q   <= 1'b1;
            survValid_q  <= 1'b0;
            survBits_q   <= '0;
            bestState_q  <= '0;
            bestMetric_q <= '0;
            cnt_q        <= '0;
            symLatched_q <= '0;
            symErase_q   <= '0;
            runMin_q     <= '0;
            runMinIdx_q  <= '0;
            for (int s = 0; s < NS; s++) begin
                pmOld_q[s] <= (s == 0) ? '0 : INIT_VAL;
                pmNew_q[s] <= '0;
            end
        end else if (clr) begin
            state_q     <= IDLE;
            symReady_q  <= 1'b1;
            survValid_q <= 1'b0;
            cnt_q       <= '0;
            for (int s = 0; s < NS; s++) begin
                pmOld_q[s] <= (s == 0) ? '0 : INIT_VAL;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.sym_valid && symReady_q) begin
                        symLatched_q <= bus.sym;
`ifdef VITERBI_ACS_ERASURE_EN
                        symErase_q   <= bus.sym_erase;
`endif
                        cnt_q        <= '0;
                        symReady_q   <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    pmNew_q[cnt_q]    <= pmNew_d;
                    survBits_q[cnt_q] <= choose1_d;
                    if ((cnt_q == '0) || (pmNew_d < runMin_q)) begin
                        runMin_q    <= pmNew_d;
                        runMinIdx_q <= cnt_q;
                    end
                    cnt_q <= cnt_q + M'(1);
                    if (cnt_q == M'(NS - 1)) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    for (int s = 0; s < NS; s++) begin
                        pmOld_q[s] <= pmNew_q[s] - runMin_q;
                    end
                    bestState_q  <= runMinIdx_q;
                    bestMetric_q <= '0;
                    survValid_q  <= 1'b1;
                    state_q      <= OUT;
                end
                OUT: begin
                    if (bus.surv_ready) begin
                        survValid_q <= 1'b0;
                        symReady_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sym_ready   = symReady_q;
    assign bus.surv_valid  = survValid_q;
    assign bus.surv_bits   = survBits_q;
    assign bus.best_state  = bestState_q;
    assign bus.best_metric = bestMetric_q;
endmodule

// File: tb/tb_viterbi_acs_serial.sv
// Directed bench for viterbi_acs_serial: single-step vectors from the reset
// metrics, backpressure, clr abort, async reset mid-step, an optional erasure
// vector, and a 64-symbol encoded stream checked against a reference model.
module tb_viterbi_acs_serial;
    localparam int K    = 5;
    localparam int M    = K - 1;
    localparam int NS   = 1 << M;
    localparam int PM_W = 8;

    typedef struct {
        logic [1:0]    sym;
        logic [NS-1:0] expSurv;
        logic [M-1:0]  expBest;
    } vec_t;

    logic clk;
    logic rst_n;
    logic clr;
    int   vecCount;
    int   missCount;
    int   mPm [NS];
    vec_t vecTable [4];

    viterbi_acs_serial_if #(.K(K), .PM_W(PM_W)) bus ();

    viterbi_acs_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream of the bounded waits misbehaves.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison; every call counts as one applied vector.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Encoder output for register {pred, b} (generators 23 and 35 octal).
    function automatic logic [1:0] encBits(input int r);
        logic [4:0] rr;
        rr = r[4:0];
        return {^(rr & 5'b10011), ^(rr & 5'b11101)};
    endfunction

    task automatic modelReset();
        for (int s = 0; s < NS; s++) mPm[s] = (s == 0) ? 0 : 64;
    endtask

    // One full trellis step over all states at once, then normalisation.
    task automatic modelStep(input logic [1:0] s, input logic [1:0] er,
                             output logic [NS-1:0] surv, output int best);
        int newPm [NS];
        int minPm;
        surv  = '0;
        minPm = 1 << 30;
        best  = 0;
        for (int st = 0; st < NS; st++) begin
            int p0, p1, c0, c1;
            logic [1:0] d0, d1;
            p0 = st >> 1;
            p1 = p0 | (NS >> 1);
            d0 = (s ^ encBits(p0 * 2 + (st & 1))) & ~er;
            d1 = (s ^ encBits(p1 * 2 + (st & 1))) & ~er;
            c0 = mPm[p0] + int'(d0[0]) + int'(d0[1]);
            c1 = mPm[p1] + int'(d1[0]) + int'(d1[1]);
            if (c0 > 255) c0 = 255;
            if (c1 > 255) c1 = 255;
            if (c1 < c0) begin
                newPm[st] = c1;
                surv[st]  = 1'b1;
            end else begin
                newPm[st] = c0;
            end
            if (newPm[st] < minPm) begin
                minPm = newPm[st];
                best  = st;
            end
        end
        for (int st = 0; st < NS; st++) mPm[st] = newPm[st] - minPm;
    endtask

    task automatic clrPulse();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Wait (bounded) for sym_ready, then perform one symbol handshake.
    // Returns in the first RUN cycle (cnt = 0).
    task automatic startSymbol(input logic [1:0] s);
        int guard;
        guard = 0;
        while (bus.sym_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("sym_ready before handshake", 32'(bus.sym_ready), 32'd1);
        bus.sym       = s;
        bus.sym_valid = 1'b1;
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
    endtask

    // Handshake one symbol and wait for the survivor word. lat counts cycles
    // from the handshake cycle to the first cycle with surv_valid high.
    task automatic applyStimulus(input logic [1:0] s, output int lat);
        startSymbol(s);
        lat = 1;
        while (bus.surv_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("surv_valid seen", 32'(bus.surv_valid), 32'd1);
    endtask

    initial begin
        int            lat;
        int            best;
        int            sawValid;
        logic [NS-1:0] surv;
        logic [63:0]   stream;
        int            encState;

        vecCount  = 0;
        missCount = 0;

        // From the reset metrics only states 0 and 1 (pred 0) are cheap; for
        // the other states both predecessors start at 64 and the two
        // predecessors' expected symbols are complements, so p1 wins exactly
        // where pred0's expected symbol is the inverse of the received one.
        vecTable[0] = '{sym: 2'b00, expSurv: 16'h2440, expBest: 4'd0};
        vecTable[1] = '{sym: 2'b11, expSurv: 16'h1880, expBest: 4'd1};
        vecTable[2] = '{sym: 2'b01, expSurv: 16'h4224, expBest: 4'd0};
        vecTable[3] = '{sym: 2'b10, expSurv: 16'h8118, expBest: 4'd0};

        rst_n          = 1'b0;
        clr            = 1'b0;
        bus.sym_valid  = 1'b0;
        bus.sym        = 2'b00;
        bus.surv_ready = 1'b1;
`ifdef VITERBI_ACS_ERASURE_EN
        bus.sym_erase  = 2'b00;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset sym_ready", 32'(bus.sym_ready), 32'd1);
        checkOutput("reset surv_valid", 32'(bus.surv_valid), 32'd0);
        checkOutput("reset surv_bits", 32'(bus.surv_bits), 32'd0);
        checkOutput("reset best_state", 32'(bus.best_state), 32'd0);
        checkOutput("reset best_metric", 32'(bus.best_metric), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single-step vectors from reset metrics");
        for (int i = 0; i < 4; i++) begin
            clrPulse();
            applyStimulus(vecTable[i].sym, lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(NS + 2));
            checkOutput($sformatf("vec%0d surv_bits", i), 32'(bus.surv_bits), 32'(vecTable[i].expSurv));
            checkOutput($sformatf("vec%0d best_state", i), 32'(bus.best_state), 32'(vecTable[i].expBest));
            checkOutput($sformatf("vec%0d best_metric", i), 32'(bus.best_metric), 32'd0);
        end

        $display("[TB] backpressure in OUT");
        clrPulse();
        bus.surv_ready = 1'b0;
        applyStimulus(2'b11, lat);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp%0d surv_valid", c), 32'(bus.surv_valid), 32'd1);
            checkOutput($sformatf("bp%0d surv_bits", c), 32'(bus.surv_bits), 32'h1880);
            checkOutput($sformatf("bp%0d best_state", c), 32'(bus.best_state), 32'd1);
            checkOutput($sformatf("bp%0d sym_ready", c), 32'(bus.sym_ready), 32'd0);
            bus.sym_valid = (c == 2);
            bus.sym       = 2'b00;
            @(posedge clk); #1;
        end
        bus.sym_valid  = 1'b0;
        bus.surv_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp release surv_valid", 32'(bus.surv_valid), 32'd0);
        checkOutput("bp release sym_ready", 32'(bus.sym_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp pulse not accepted", 32'(bus.sym_ready), 32'd1);

        $display("[TB] clr abort at cnt 7");
        clrPulse();
        startSymbol(2'b11);
        repeat (7) @(posedge clk);
        #1;
        clrPulse();
        checkOutput("clr sym_ready", 32'(bus.sym_ready), 32'd1);
        checkOutput("clr surv_valid", 32'(bus.surv_valid), 32'd0);
        sawValid = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.surv_valid === 1'b1) sawValid++;
            @(posedge clk); #1;
        end
        checkOutput("clr no stale word", 32'(sawValid), 32'd0);
        applyStimulus(2'b00, lat);
        checkOutput("post-clr latency", 32'(lat), 32'(NS + 2));
        checkOutput("post-clr surv_bits", 32'(bus.surv_bits), 32'h2440);
        checkOutput("post-clr best_state", 32'(bus.best_state), 32'd0);

        $display("[TB] async reset mid-step");
        @(posedge clk); #1;
        startSymbol(2'b11);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst sym_ready", 32'(bus.sym_ready), 32'd1);
        checkOutput("async rst surv_valid", 32'(bus.surv_valid), 32'd0);
        checkOutput("async rst surv_bits", 32'(bus.surv_bits), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(2'b11, lat);
        checkOutput("after rst surv_bits", 32'(bus.surv_bits), 32'h1880);
        checkOutput("after rst best_state", 32'(bus.best_state), 32'd1);

`ifdef VITERBI_ACS_ERASURE_EN
        $display("[TB] erasure vector");
        clrPulse();
        bus.sym_erase = 2'b01;
        applyStimulus(2'b10, lat);
        bus.sym_erase = 2'b00;
        checkOutput("erase surv_bits", 32'(bus.surv_bits), 32'h9998);
        checkOutput("erase best_state", 32'(bus.best_state), 32'd1);
`endif

        $display("[TB] encoded 64-symbol stream with one flipped bit");
        @(posedge clk); #1;
        clrPulse();
        modelReset();
        stream   = 64'hA5C3_1F07_9B2E_64D8;
        encState = 0;
        for (int i = 0; i < 64; i++) begin
            int         r;
            logic [1:0] s;
            r        = encState * 2 + int'(stream[i]);
            s        = encBits(r);
            encState = r & (NS - 1);
            if (i == 20) s = s ^ 2'b01;
            modelStep(s, 2'b00, surv, best);
            applyStimulus(s, lat);
            checkOutput($sformatf("stream%0d surv_bits", i), 32'(bus.surv_bits), 32'(surv));
            checkOutput($sformatf("stream%0d best_state", i), 32'(bus.best_state), 32'(best));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
